i2c_txn_scheduler: RTL
======================

# i2c_txn_scheduler

Round-robin transaction scheduler that shares the single I2C master controller between NUM_REQ on-chip requesters such as APB command slots and DMA. It latches one requester's address/direction/length, drives the master's enable/address/data inputs byte by byte, counts acknowledged bytes and reports per-requester completion with error status. It sits between the APB register/FIFO layer and the I2C master, in the core_clk domain.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- LEN_W, 4, width of byte-count field
- TIMEOUT_CYCLES, 4096, core_clk cycles allowed between byte completions (only with timeout compiled in)

- core_clk  in  1  system clock
- rst_n  in  1  reset; asynchronous assert, active-low
- req  in  NUM_REQ  level request; held until matching done
- req_addr  in  8*NUM_REQ  per requester {7-bit slave addr, rw}; rw=1 read
- req_len  in  LEN_W*NUM_REQ  bytes to transfer
- req_wdata  in  8*NUM_REQ  current write byte; requester advances on wdata_take
- gnt  out  NUM_REQ  one-hot grant, high for whole transaction
- wdata_take  out  NUM_REQ  1-cycle pulse: req_wdata byte consumed
- done  out  NUM_REQ  1-cycle completion pulse
- err  out  1  valid with done: 1 = NACK, len 0, or timeout
- i2c_enable  out  1  to master enable
- i2c_slave_address  out  8  to master slave_address
- i2c_data_in  out  8  to master data_in
- i2c_byte_done  in  1  master pulse: byte ACK phase finished with ACK
- i2c_nack  in  1  master pulse: NACK received
- i2c_idle  in  1  master back in IDLE

## Operation
- States: IDLE, GRANT, RUN, WAIT_IDLE, FINISH.
- IDLE: if any req, select first set bit searching from last_grant+1 (wrap) → latch index, set gnt → GRANT.
- GRANT: capture addr, len into internal regs. len==0 → err=1 → FINISH (master never enabled). Else remaining=len, i2c_slave_address=addr; for write, i2c_data_in=req_wdata[idx], pulse wdata_take[idx]; i2c_enable=1 → RUN.
- RUN: i2c_nack → i2c_enable=0, err=1 → WAIT_IDLE. i2c_byte_done → remaining-1; if remaining was 1 → i2c_enable=0 → WAIT_IDLE; else for write load next req_wdata, pulse wdata_take.
- WAIT_IDLE: i2c_idle=1 → FINISH.
- FINISH: pulse done[idx] with err, clear gnt, last_grant=idx, err cleared next cycle → IDLE.
- Simultaneous i2c_byte_done and i2c_nack: NACK wins, byte not counted.
- req dropped mid-transaction: ignored; transaction completes normally.
- Repeated start not generated; master's repeated_start_cond tied 0 at integration.
- Reset at any point: all outputs 0 immediately, state IDLE, last_grant=NUM_REQ-1 (requester 0 first), remaining=0.

## Timing
- req seen high in IDLE cycle N → gnt cycle N+1, i2c_enable and first wdata_take cycle N+2.
- i2c_data_in updated the cycle after i2c_byte_done, well before the master's next bit phase.
- done one cycle after i2c_idle sampled high in WAIT_IDLE.
- Minimum gap between transactions: 2 cycles (FINISH, IDLE).
- remaining is LEN_W bits, unsigned, no wrap: only decremented in RUN when ≥1.

## Configuration
- I2C_TXN_TIMEOUT_EN defined: counter reset on entering RUN and on each i2c_byte_done; reaching TIMEOUT_CYCLES-1 in RUN or WAIT_IDLE → i2c_enable=0, err=1, directly to FINISH.
- Undefined: no counter; RUN/WAIT_IDLE wait indefinitely.

## Structure
- Package i2c_pkg: state encoding constants, I2C_ADDR_W=7, I2C_BYTE_W=8, rw bit position.
- Sub-module i2c_rr_arbiter: combinational round-robin pick (req, last_grant → one-hot + index), parameterised on NUM_REQ.

## Test plan
- req[0] write addr 0x50, len 2, bytes 0xA5,0x3C → gnt[0] next cycle, i2c_slave_address=0xA0, data_in 0xA5 then 0x3C, two wdata_take[0], done[0] err=0.
- req[0] and req[2] held continuously → grant order 0,2,0,2; no gap under 2 cycles.
- Write len 3, i2c_nack after first byte → one wdata_take, i2c_enable drops next cycle, done err=1.
- req[1] len 0 → done[1] err=1 within 3 cycles of gnt, i2c_enable never high.
- Read addr 0x51 len 3 → i2c_slave_address=0xA3, no wdata_take, enable drops after third byte_done, done err=0.
- With I2C_TXN_TIMEOUT_EN, no byte_done for TIMEOUT_CYCLES → done err=1; rst_n low mid-RUN → all outputs 0 same cycle.

Source files
------------

// File: rtl/i2c_txn_scheduler_pkg.sv
// Shared state encoding and I2C field constants for the transaction scheduler.
package i2c_pkg;

  localparam int I2C_ADDR_W = 7;
  localparam int I2C_BYTE_W = I2C_ADDR_W + 1;
  localparam int I2C_RW_BIT = 0;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_GRANT     = 3'd1,
    ST_RUN       = 3'd2,
    ST_WAIT_IDLE = 3'd3,
    ST_FINISH    = 3'd4
  } sched_state_e;

  function automatic logic addr_is_read(input logic [I2C_BYTE_W-1:0] addr_byte);
    return addr_byte[I2C_RW_BIT];
  endfunction

endpackage

// File: rtl/i2c_txn_scheduler_if.sv
// Link between the scheduler (master modport) and the I2C master controller (slave modport).
interface i2c_txn_scheduler_if;
  import i2c_pkg::*;

  logic                  i2c_enable;
  logic [I2C_BYTE_W-1:0] i2c_slave_address;
  logic [I2C_BYTE_W-1:0] i2c_data_in;
  logic                  i2c_byte_done;
  logic                  i2c_nack;
  logic                  i2c_idle;

  modport master (
    output i2c_enable, i2c_slave_address, i2c_data_in,
    input  i2c_byte_done, i2c_nack, i2c_idle
  );

  modport slave (
    input  i2c_enable, i2c_slave_address, i2c_data_in,
    output i2c_byte_done, i2c_nack, i2c_idle
  );
endinterface

// File: rtl/i2c_txn_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set request searching upward from last_grant+1 with wrap.
module i2c_rr_arbiter
  import i2c_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [NUM_REQ-1:0] gnt_oh,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_vld
);

  logic [IDX_W-1:0] cand_s;

  // Walk candidates in priority order; the first hit wins.
  always_comb begin
    gnt_oh  = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    cand_s  = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand_s = IDX_W'((int'(last_grant) + i) % NUM_REQ);
      if (!gnt_vld && req[cand_s]) begin
        gnt_vld        = 1'b1;
        gnt_idx        = cand_s;
        gnt_oh[cand_s] = 1'b1;
      end else begin
        gnt_vld = gnt_vld;
      end
    end
  end

endmodule

// File: rtl/i2c_txn_scheduler.sv
// Round-robin scheduler sharing one I2C master among NUM_REQ requesters.
// Optional per-byte watchdog is compiled in with I2C_TXN_TIMEOUT_EN.
module i2c_txn_scheduler
  import i2c_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int LEN_W   = 4
`ifdef I2C_TXN_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 4096
`endif
) (
  input  logic                          core_clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [I2C_BYTE_W*NUM_REQ-1:0] req_addr,
  input  logic [LEN_W*NUM_REQ-1:0]      req_len,
  input  logic [I2C_BYTE_W*NUM_REQ-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            wdata_take,
  output logic [NUM_REQ-1:0]            done,
  output logic                          err,
  i2c_txn_scheduler_if.master           i2c
);

  localparam int IDX_W = $clog2(NUM_REQ);

  sched_state_e          state_r, state_s;
  logic [IDX_W-1:0]      idx_r, idx_s, last_grant_r, last_grant_s, pick_idx_s;
  logic [NUM_REQ-1:0]    gnt_r, gnt_s, take_r, take_s, done_r, done_s, pick_oh_s;
  logic                  pick_vld_s, err_r, err_s, err_pend_r, err_pend_s;
  logic                  enable_r, enable_s, rw_r, rw_s, tmo_hit_s;
  logic [I2C_BYTE_W-1:0] addr_r, addr_s, data_r, data_s, cur_addr_s, cur_wdata_s;
  logic [LEN_W-1:0]      rem_r, rem_s, cur_len_s;

  i2c_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req        (req),
    .last_grant (last_grant_r),
    .gnt_oh     (pick_oh_s),
    .gnt_idx    (pick_idx_s),
    .gnt_vld    (pick_vld_s)
  );

  assign cur_addr_s  = req_addr[idx_r*I2C_BYTE_W +: I2C_BYTE_W];
  assign cur_wdata_s = req_wdata[idx_r*I2C_BYTE_W +: I2C_BYTE_W];
  assign cur_len_s   = req_len[idx_r*LEN_W +: LEN_W];

`ifdef I2C_TXN_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
  logic [TMO_W-1:0] tmo_cnt_r;

  // Watchdog restarts on entry to RUN and on every acknowledged byte.
  always_ff @(posedge core_clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_r <= '0;
    end else if (state_r == ST_GRANT || i2c.i2c_byte_done) begin
      tmo_cnt_r <= '0;
    end else if ((state_r == ST_RUN || state_r == ST_WAIT_IDLE) && !tmo_hit_s) begin
      tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
    end else begin
      tmo_cnt_r <= tmo_cnt_r;
    end
  end

  assign tmo_hit_s = (state_r == ST_RUN || state_r == ST_WAIT_IDLE) &&
                     (tmo_cnt_r == TMO_W'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_hit_s = 1'b0;
`endif

  // Next-state and next-output computation for the transaction FSM.
  always_comb begin
    state_s      = state_r;
    idx_s        = idx_r;
    last_grant_s = last_grant_r;
    gnt_s        = gnt_r;
    take_s       = '0;
    done_s       = '0;
    err_s        = 1'b0;
    err_pend_s   = err_pend_r;
    enable_s     = enable_r;
    addr_s       = addr_r;
    data_s       = data_r;
    rem_s        = rem_r;
    rw_s         = rw_r;
    case (state_r)
      ST_IDLE: begin
        if (pick_vld_s) begin
          idx_s      = pick_idx_s;
          gnt_s      = pick_oh_s;
          err_pend_s = 1'b0;
          state_s    = ST_GRANT;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_GRANT: begin
        rw_s  = addr_is_read(cur_addr_s);
        rem_s = cur_len_s;
        if (cur_len_s == '0) begin
          err_pend_s = 1'b1;
          state_s    = ST_FINISH;
        end else begin
          addr_s   = cur_addr_s;
          enable_s = 1'b1;
          state_s  = ST_RUN;
          if (!addr_is_read(cur_addr_s)) begin
            data_s = cur_wdata_s;
            take_s = gnt_r;
          end else begin
            data_s = data_r;
          end
        end
      end
      ST_RUN: begin
        // NACK outranks a coincident byte_done, so that byte is never counted.
        if (tmo_hit_s) begin
          enable_s   = 1'b0;
          err_pend_s = 1'b1;
          state_s    = ST_FINISH;
        end else if (i2c.i2c_nack) begin
          enable_s   = 1'b0;
          err_pend_s = 1'b1;
          state_s    = ST_WAIT_IDLE;
        end else if (i2c.i2c_byte_done) begin
          if (rem_r != '0) begin
            rem_s = rem_r - LEN_W'(1);
          end else begin
            rem_s = rem_r;
          end
          if (rem_r == LEN_W'(1)) begin
            enable_s = 1'b0;
            state_s  = ST_WAIT_IDLE;
          end else if (!rw_r) begin
            data_s = cur_wdata_s;
            take_s = gnt_r;
          end else begin
            data_s = data_r;
          end
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_WAIT_IDLE: begin
        if (tmo_hit_s) begin
          err_pend_s = 1'b1;
          state_s    = ST_FINISH;
        end else if (i2c.i2c_idle) begin
          state_s = ST_FINISH;
        end else begin
          state_s = ST_WAIT_IDLE;
        end
      end
      ST_FINISH: begin
        gnt_s        = '0;
        last_grant_s = idx_r;
        state_s      = ST_IDLE;
      end
      default: begin
        gnt_s    = '0;
        enable_s = 1'b0;
        state_s  = ST_IDLE;
      end
    endcase
    // done/err are registered so they appear during the FINISH cycle itself.
    if (state_s == ST_FINISH && state_r != ST_FINISH) begin
      done_s = gnt_r;
      err_s  = err_pend_s;
    end else begin
      done_s = '0;
    end
  end

  // State and registered-output update.
  always_ff @(posedge core_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      idx_r        <= '0;
      last_grant_r <= IDX_W'(NUM_REQ - 1);
      gnt_r        <= '0;
      take_r       <= '0;
      done_r       <= '0;
      err_r        <= 1'b0;
      err_pend_r   <= 1'b0;
      enable_r     <= 1'b0;
      addr_r       <= '0;
      data_r       <= '0;
      rem_r        <= '0;
      rw_r         <= 1'b0;
    end else begin
      state_r      <= state_s;
      idx_r        <= idx_s;
      last_grant_r <= last_grant_s;
      gnt_r        <= gnt_s;
      take_r       <= take_s;
      done_r       <= done_s;
      err_r        <= err_s;
      err_pend_r   <= err_pend_s;
      enable_r     <= enable_s;
      addr_r       <= addr_s;
      data_r       <= data_s;
      rem_r        <= rem_s;
      rw_r         <= rw_s;
    end
  end

  assign gnt                   = gnt_r;
  assign wdata_take            = take_r;
  assign done                  = done_r;
  assign err                   = err_r;
  assign i2c.i2c_enable        = enable_r;
  assign i2c.i2c_slave_address = addr_r;
  assign i2c.i2c_data_in       = data_r;

endmodule
